arm_imm_encoder: RTL
====================

// Module: arm_imm_encoder
// PURPOSE
//   Iterative encoder for the ARM data-processing immediate (inverse of the EXE
//   Val2 immediate rotator). Given a 32-bit constant, finds {rotate_imm, immed_8}
//   such that ROR(zext(immed_8), 2*rotate_imm) == value. If no direct encoding
//   exists, tries ~value instead, so the caller can emit MVN/BIC in place of MOV/AND.
//   Used by the constant-loading / test-program path in front of ID/EXE.
//   Tests one rotation per cycle under a valid/ready handshake on each side.
// PARAMETERS
//   TRY_INVERTED  1   1: evaluate ~value in parallel with value; 0: direct only
// PORTS
//   clk            in   1   clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   in_valid       in   1   value is valid
//   in_ready       out  1   encoder can accept a value (high in IDLE only)
//   value          in   32  constant to encode
//   out_valid      out  1   result is valid (high in DONE only)
//   out_ready      in   1   consumer takes the result
//   found          out  1   encoding exists (direct or inverted)
//   inverted       out  1   encoding is of ~value
//   shift_operand  out  12  {rotate_imm[3:0], immed_8[7:0]}; 12'h000 when !found
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, rot_cnt=0, captured value=0.
//     Outputs: in_ready=1, out_valid=0, found=0, inverted=0, shift_operand=0.
//   - FSM states: IDLE, SEARCH, DONE.
//     IDLE: in_ready=1. On in_valid&&in_ready, capture value, clear rot_cnt,
//       go to SEARCH.
//     SEARCH: each cycle, form cand = ROL(val_q, 2*rot_cnt) and
//       cand_n = ROL(~val_q, 2*rot_cnt) (both 32-bit rotates, wrap-around).
//       Direct hit: cand[31:8]==0. Inverted hit: TRY_INVERTED && cand_n[31:8]==0.
//       On a direct hit: register found=1, inverted=0,
//         shift_operand={rot_cnt, cand[7:0]}, go to DONE.
//       Otherwise, on an inverted hit: found=1, inverted=1,
//         shift_operand={rot_cnt, cand_n[7:0]}, go to DONE.
//       Otherwise, if rot_cnt==15: found=0, inverted=0, shift_operand=0, go to DONE.
//       Otherwise: rot_cnt <= rot_cnt+1.
//     DONE: out_valid=1. Result registers are held stable while out_ready=0.
//       On out_ready, go to IDLE. No new input is accepted in the same cycle.
//   - Priority: lowest rot_cnt wins. At equal rot_cnt, a direct hit beats an
//     inverted hit. An inverted hit at a lower rot beats a direct hit at a higher rot.
//   - Latency: accept at cycle T. rot r is tested at cycle T+1+r. out_valid rises
//     at T+2+r for a hit at r. Worst case (no hit) out_valid rises at T+17.
//   - value=0: direct hit at rot 0, shift_operand=12'h000, found=1.
//   - Result registers update only on the SEARCH->DONE transition. They are cleared
//     only by reset; in IDLE they hold the last result (out_valid=0).
//   - Reset asserted mid-SEARCH or in DONE: immediate return to IDLE with reset
//     values. The pending result is discarded.
//   - All arithmetic is unsigned. rot_cnt is 4 bits and never wraps: the search
//     terminates at 15.
// TESTING
//   1. value=32'h000000FF -> found=1, inverted=0, shift_operand=12'h0FF,
//      out_valid at T+2.
//   2. value=32'hFF000000 -> shift_operand=12'h4FF (rot 4); value=32'hF000000F ->
//      12'h2FF (rot 2); value=32'h000003FC -> 12'hFFF (rot 15), out_valid at T+17.
//   3. value=32'hFFFFFF00 -> found=1, inverted=1, shift_operand=12'h0FF;
//      with TRY_INVERTED=0 -> found=0, shift_operand=0 at T+17.
//   4. value=32'h00000101 -> found=0, inverted=0, shift_operand=0, out_valid at T+17.
//   5. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and result stable,
//      in_ready=0. Then out_ready=1 -> IDLE next cycle, in_ready=1.
//   6. rst_n pulsed low at T+5 during the search for 32'h00000101 ->
//      out_valid=0, in_ready=1 immediately. A next input of 32'h000000FF then
//      encodes correctly.

Source files
------------

// File: rtl/arm_imm_encoder_if.sv
// Handshake bus for the ARM immediate encoder: a value goes in, a
// {rotate_imm, immed_8} result comes out.
interface arm_imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] value;
    logic        out_valid;
    logic        out_ready;
    logic        found;
    logic        inverted;
    logic [11:0] shift_operand;

    modport master (
        output in_valid, value, out_ready,
        input  in_ready, out_valid, found, inverted, shift_operand
    );

    modport slave (
        input  in_valid, value, out_ready,
        output in_ready, out_valid, found, inverted, shift_operand
    );
endinterface

// File: rtl/arm_imm_encoder.sv
// Iterative ARM data-processing immediate encoder: tests one even rotation per
// cycle and falls back to ~value so the caller can swap MOV/AND for MVN/BIC.
module arm_imm_encoder #(
    parameter bit TRY_INVERTED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    arm_imm_encoder_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]  state;
    logic [3:0]  rot_cnt;
    logic [31:0] val_q;
    logic        found_q;
    logic        inverted_q;
    logic [11:0] shift_q;

    logic [63:0] dbl;
    logic [63:0] dbl_n;
    logic [31:0] cand;
    logic [31:0] cand_n;
    logic        direct_hit;
    logic        inv_hit;

    // Rotating left by 2*rot_cnt undoes the rotator's ROR, so a hit leaves
    // only the low byte populated.
    always_comb begin
        dbl        = {val_q, val_q} << {rot_cnt, 1'b0};
        dbl_n      = {~val_q, ~val_q} << {rot_cnt, 1'b0};
        cand       = dbl[63:32];
        cand_n     = dbl_n[63:32];
        direct_hit = (cand[31:8] == 24'd0);
        inv_hit    = TRY_INVERTED && (cand_n[31:8] == 24'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rot_cnt    <= 4'd0;
            val_q      <= 32'd0;
            found_q    <= 1'b0;
            inverted_q <= 1'b0;
            shift_q    <= 12'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        val_q   <= bus.value;
                        rot_cnt <= 4'd0;
                        state   <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (direct_hit) begin
                        found_q    <= 1'b1;
                        inverted_q <= 1'b0;
                        shift_q    <= {rot_cnt, cand[7:0]};
                        state      <= DONE;
                    end else if (inv_hit) begin
                        found_q    <= 1'b1;
                        inverted_q <= 1'b1;
                        shift_q    <= {rot_cnt, cand_n[7:0]};
                        state      <= DONE;
                    end else if (rot_cnt == 4'd15) begin
                        found_q    <= 1'b0;
                        inverted_q <= 1'b0;
                        shift_q    <= 12'd0;
                        state      <= DONE;
                    end else begin
                        rot_cnt <= rot_cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = (state == IDLE);
    assign bus.out_valid     = (state == DONE);
    assign bus.found         = found_q;
    assign bus.inverted      = inverted_q;
    assign bus.shift_operand = shift_q;

endmodule
